dma_channel_scheduler: RTL and testbench
========================================

Name: dma_channel_scheduler

Overview:
Front-end sequencer for the 4-channel DMA engine. Each requester channel posts one descriptor into a private single-entry slot. A round-robin arbiter picks one eligible slot at a time and pulses start into the single engine. It then waits for the engine's done pulse and returns per-channel completion and error status.

Parameters:
NUM_CHANNELS, 4, number of requester channels (channel_sel width = $clog2(NUM_CHANNELS), minimum 1)
ADDR_W, 40, source/destination address width
LEN_W, 24, transfer length width in bytes
BEAT_BYTES, 16, engine beat size in bytes (AXI_DATA_W/8); legal lengths are non-zero multiples of this

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ch_valid  input  NUM_CHANNELS  per-channel descriptor valid
ch_ready  output  NUM_CHANNELS  per-channel slot empty (accept when valid&&ready)
ch_src_addr  input  NUM_CHANNELS*ADDR_W  packed per-channel source address
ch_dst_addr  input  NUM_CHANNELS*ADDR_W  packed per-channel destination address
ch_length  input  NUM_CHANNELS*LEN_W  packed per-channel length in bytes
ch_flags  input  NUM_CHANNELS*8  packed per-channel flags (bit0 1=read external, 0=write external)
ch_enable  input  NUM_CHANNELS  arbitration enable mask
ch_done  output  NUM_CHANNELS  one-cycle completion pulse, per channel
ch_err  output  NUM_CHANNELS  one-cycle error pulse, coincident with ch_done
err_status  output  NUM_CHANNELS  sticky error flags
err_clear  input  NUM_CHANNELS  write-1-to-clear for err_status
eng_start  output  1  engine start pulse
eng_channel_sel  output  $clog2(NUM_CHANNELS)  granted channel index
eng_src_addr  output  ADDR_W  descriptor source address to engine
eng_dst_addr  output  ADDR_W  descriptor destination address to engine
eng_length  output  LEN_W  descriptor length to engine
eng_flags  output  8  descriptor flags to engine
eng_busy  input  1  engine busy
eng_done  input  1  engine completion pulse
eng_error  input  1  engine error (level, sampled every cycle)
sched_busy  output  1  high whenever the FSM is not IDLE
xfer_count  output  32  total completed descriptors, wrapping, errors included

Behaviour:
- Reset: all slots empty. ch_ready = all ones. All other outputs 0, including the eng_* descriptor fields. rr_ptr = 0. FSM = IDLE.
- Slots:
  - ch_ready[i] = !slot_full[i], registered state.
  - Accept on valid&&ready captures that channel's fields. The slot becomes visible to the arbiter the next cycle.
  - A slot cleared on cycle N accepts again from cycle N+1.
- FSM states and transitions:
  - IDLE: eligible = slot_full & ch_enable. If eligible != 0 and !eng_busy, grant the first eligible index searching upward from rr_ptr with wrap, and latch grant.
    - Legal length: go to ISSUE.
    - length == 0 or length % BEAT_BYTES != 0: go to REJECT.
  - ISSUE: eng_start = 1 for exactly this one cycle. eng_channel_sel and the descriptor fields are driven from the granted slot and held stable until leaving WAIT. Next state WAIT; clear err_seen.
  - WAIT: OR eng_error into err_seen each cycle. When eng_done is high:
    - ch_done[g] = 1; ch_err[g] = err_seen | eng_error.
    - Clear slot g; rr_ptr = (g+1) mod NUM_CHANNELS; xfer_count += 1.
    - Go to IDLE.
  - REJECT: no eng_start. ch_done[g] = ch_err[g] = 1, clear slot g, advance rr_ptr, xfer_count += 1, then go to IDLE.
- Latency: with the engine idle and no contention, eng_start rises in the 2nd cycle after the accepting edge. The minimum gap from eng_done to the next eng_start is 2 cycles.
- err_status[i]:
  - Set on ch_err[i].
  - Cleared by err_clear[i].
  - Set wins when set and clear occur in the same cycle.
- ch_enable deasserted mid-transfer: the in-flight transfer completes normally. The pending slot is kept, not dropped, and is not granted until re-enabled.
- eng_done while not in WAIT is ignored.
- Reset mid-transfer: everything returns to reset values immediately; the engine is reset by the same rst_n.
- xfer_count wraps 0xFFFFFFFF -> 0.

Test Plan:
- Single read: ch1 posts src=0x1000_0000, dst=0x0, len=64, flags=1 -> eng_start 2 cycles later with channel_sel=1 and fields exact; engine model pulses done -> ch_done[1] one cycle, ch_err=0, xfer_count=1.
- Round-robin: all 4 slots loaded in the same cycle, rr_ptr=0 -> grant order 0,1,2,3; reload ch0 and ch2 after ch1 completes -> order continues 2 then 0.
- Illegal length: len=0 on ch3, then len=24 on ch2 -> no eng_start for either; ch_done and ch_err pulse for each; err_status=4'b1100; err_clear=4'b0100 -> 4'b1000.
- Engine error: eng_error pulsed for one cycle mid-WAIT on ch0 -> ch_err[0]=1 at done; set/clear collision on the same cycle leaves err_status[0]=1.
- Gating and busy: ch_enable=4'b1101 with ch1 loaded -> ch1 never granted until enabled; eng_busy held high in IDLE -> no grant until it falls.
- Reset mid-WAIT: rst_n low -> ch_ready=4'hF, sched_busy=0, eng_start=0, xfer_count=0.

Source files
------------

// File: rtl/dma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_scheduler
// Function : Per-channel descriptor slots, round-robin grant into a single DMA
//            engine, completion pulses, sticky error status, transfer count.
// Revision : 1.0
// ============================================================================
module dma_channel_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = 40,
    parameter int LEN_W        = 24,
    parameter int BEAT_BYTES   = 16,
    localparam int SEL_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHANNELS-1:0]        ch_valid,
    output logic [NUM_CHANNELS-1:0]        ch_ready,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] ch_src_addr,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] ch_dst_addr,
    input  logic [NUM_CHANNELS*LEN_W-1:0]  ch_length,
    input  logic [NUM_CHANNELS*8-1:0]      ch_flags,
    input  logic [NUM_CHANNELS-1:0]        ch_enable,
    output logic [NUM_CHANNELS-1:0]        ch_done,
    output logic [NUM_CHANNELS-1:0]        ch_err,
    output logic [NUM_CHANNELS-1:0]        err_status,
    input  logic [NUM_CHANNELS-1:0]        err_clear,
    output logic                           eng_start,
    output logic [SEL_W-1:0]               eng_channel_sel,
    output logic [ADDR_W-1:0]              eng_src_addr,
    output logic [ADDR_W-1:0]              eng_dst_addr,
    output logic [LEN_W-1:0]               eng_length,
    output logic [7:0]                     eng_flags,
    input  logic                           eng_busy,
    input  logic                           eng_done,
    input  logic                           eng_error,
    output logic                           sched_busy,
    output logic [31:0]                    xfer_count
);

    localparam int IDX_W = SEL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    state_t                    r_state;
    logic [SEL_W-1:0]          r_grant;
    logic [SEL_W-1:0]          r_rr_ptr;
    logic                      r_err_seen;
    logic                      r_eng_start;
    logic [SEL_W-1:0]          r_eng_sel;
    logic [ADDR_W-1:0]         r_eng_src;
    logic [ADDR_W-1:0]         r_eng_dst;
    logic [LEN_W-1:0]          r_eng_len;
    logic [7:0]                r_eng_flags;
    logic [NUM_CHANNELS-1:0]   r_ch_done;
    logic [NUM_CHANNELS-1:0]   r_ch_err;
    logic [NUM_CHANNELS-1:0]   r_err_status;
    logic [31:0]               r_xfer_count;

    logic [NUM_CHANNELS-1:0]   r_slot_full;
    logic [ADDR_W-1:0]         r_slot_src   [NUM_CHANNELS];
    logic [ADDR_W-1:0]         r_slot_dst   [NUM_CHANNELS];
    logic [LEN_W-1:0]          r_slot_len   [NUM_CHANNELS];
    logic [7:0]                r_slot_flags [NUM_CHANNELS];

    logic [ADDR_W-1:0]         w_src   [NUM_CHANNELS];
    logic [ADDR_W-1:0]         w_dst   [NUM_CHANNELS];
    logic [LEN_W-1:0]          w_len   [NUM_CHANNELS];
    logic [7:0]                w_flags [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]   w_accept;
    logic [NUM_CHANNELS-1:0]   w_elig;
    logic [NUM_CHANNELS-1:0]   w_slot_clr;
    logic                      w_any_elig;
    logic [SEL_W-1:0]          w_grant_idx;
    logic [IDX_W-1:0]          w_scan_idx;
    logic [LEN_W-1:0]          w_grant_len;
    logic                      w_len_ok;
    logic [SEL_W-1:0]          w_rr_next;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
        assign w_src[i]   = ch_src_addr[i*ADDR_W +: ADDR_W];
        assign w_dst[i]   = ch_dst_addr[i*ADDR_W +: ADDR_W];
        assign w_len[i]   = ch_length[i*LEN_W +: LEN_W];
        assign w_flags[i] = ch_flags[i*8 +: 8];
    end

    assign w_accept = ch_valid & ~r_slot_full;
    assign w_elig   = r_slot_full & ch_enable;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any_elig  = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, r_rr_ptr} + IDX_W'(k);
            if (w_scan_idx >= IDX_W'(NUM_CHANNELS)) begin
                w_scan_idx = w_scan_idx - IDX_W'(NUM_CHANNELS);
            end
            if (w_elig[w_scan_idx[SEL_W-1:0]]) begin
                w_any_elig  = 1'b1;
                w_grant_idx = w_scan_idx[SEL_W-1:0];
            end
        end
    end

    assign w_grant_len = r_slot_len[w_grant_idx];
    assign w_len_ok    = (w_grant_len != '0) &&
                         ((w_grant_len % LEN_W'(BEAT_BYTES)) == '0);
    assign w_rr_next   = (r_grant == SEL_W'(NUM_CHANNELS - 1)) ? '0 : r_grant + SEL_W'(1);

    always_comb begin
        w_slot_clr = '0;
        if ((r_state == S_WAIT && eng_done) || r_state == S_REJECT) begin
            w_slot_clr[r_grant] = 1'b1;
        end
    end

    // A slot freed this cycle shows ready next cycle, so accept and clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_full <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_slot_src[i]   <= '0;
                r_slot_dst[i]   <= '0;
                r_slot_len[i]   <= '0;
                r_slot_flags[i] <= '0;
            end
        end else begin
            r_slot_full <= (r_slot_full & ~w_slot_clr) | w_accept;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_accept[i]) begin
                    r_slot_src[i]   <= w_src[i];
                    r_slot_dst[i]   <= w_dst[i];
                    r_slot_len[i]   <= w_len[i];
                    r_slot_flags[i] <= w_flags[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_err_seen   <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_sel    <= '0;
            r_eng_src    <= '0;
            r_eng_dst    <= '0;
            r_eng_len    <= '0;
            r_eng_flags  <= '0;
            r_ch_done    <= '0;
            r_ch_err     <= '0;
            r_xfer_count <= '0;
        end else begin
            r_eng_start <= 1'b0;
            r_ch_done   <= '0;
            r_ch_err    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig && !eng_busy) begin
                        r_grant <= w_grant_idx;
                        if (w_len_ok) begin
                            r_state     <= S_ISSUE;
                            r_eng_start <= 1'b1;
                            r_eng_sel   <= w_grant_idx;
                            r_eng_src   <= r_slot_src[w_grant_idx];
                            r_eng_dst   <= r_slot_dst[w_grant_idx];
                            r_eng_len   <= w_grant_len;
                            r_eng_flags <= r_slot_flags[w_grant_idx];
                        end else begin
                            r_state <= S_REJECT;
                        end
                    end
                end
                S_ISSUE: begin
                    r_err_seen <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_err_seen <= r_err_seen | eng_error;
                    if (eng_done) begin
                        r_ch_done[r_grant] <= 1'b1;
                        r_ch_err[r_grant]  <= r_err_seen | eng_error;
                        r_rr_ptr           <= w_rr_next;
                        r_xfer_count       <= r_xfer_count + 32'd1;
                        r_state            <= S_IDLE;
                    end
                end
                S_REJECT: begin
                    r_ch_done[r_grant] <= 1'b1;
                    r_ch_err[r_grant]  <= 1'b1;
                    r_rr_ptr           <= w_rr_next;
                    r_xfer_count       <= r_xfer_count + 32'd1;
                    r_state            <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Set has priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_status <= '0;
        end else begin
            r_err_status <= (r_err_status & ~err_clear) | r_ch_err;
        end
    end

    assign ch_ready        = ~r_slot_full;
    assign ch_done         = r_ch_done;
    assign ch_err          = r_ch_err;
    assign err_status      = r_err_status;
    assign eng_start       = r_eng_start;
    assign eng_channel_sel = r_eng_sel;
    assign eng_src_addr    = r_eng_src;
    assign eng_dst_addr    = r_eng_dst;
    assign eng_length      = r_eng_len;
    assign eng_flags       = r_eng_flags;
    assign sched_busy      = (r_state != S_IDLE);
    assign xfer_count      = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_channel_scheduler
// Function : Scoreboard bench for dma_channel_scheduler with a simple engine model.
// Revision : 1.0
// ============================================================================
module tb_dma_channel_scheduler;

    localparam int N  = 4;
    localparam int AW = 40;
    localparam int LW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ch_valid;
    logic [N-1:0]    ch_ready;
    logic [N*AW-1:0] ch_src_addr;
    logic [N*AW-1:0] ch_dst_addr;
    logic [N*LW-1:0] ch_length;
    logic [N*8-1:0]  ch_flags;
    logic [N-1:0]    ch_enable;
    logic [N-1:0]    ch_done;
    logic [N-1:0]    ch_err;
    logic [N-1:0]    err_status;
    logic [N-1:0]    err_clear;
    logic            eng_start;
    logic [1:0]      eng_channel_sel;
    logic [AW-1:0]   eng_src_addr;
    logic [AW-1:0]   eng_dst_addr;
    logic [LW-1:0]   eng_length;
    logic [7:0]      eng_flags;
    logic            eng_busy;
    logic            eng_done;
    logic            eng_error;
    logic            sched_busy;
    logic [31:0]     xfer_count;

    dma_channel_scheduler #(
        .NUM_CHANNELS(N), .ADDR_W(AW), .LEN_W(LW), .BEAT_BYTES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr),
        .ch_length(ch_length), .ch_flags(ch_flags),
        .ch_enable(ch_enable), .ch_done(ch_done), .ch_err(ch_err),
        .err_status(err_status), .err_clear(err_clear),
        .eng_start(eng_start), .eng_channel_sel(eng_channel_sel),
        .eng_src_addr(eng_src_addr), .eng_dst_addr(eng_dst_addr),
        .eng_length(eng_length), .eng_flags(eng_flags),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_error(eng_error),
        .sched_busy(sched_busy), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [39:0] src;
        logic [39:0] dst;
        logic [23:0] len;
        logic [7:0]  flags;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_count = 0;
        tick();
    endtask

    task automatic load(input int ch, input logic [39:0] src, input logic [39:0] dst,
                        input logic [23:0] len, input logic [7:0] flags, input bit err);
        exp_t e;
        ch_src_addr[ch*AW +: AW] = src;
        ch_dst_addr[ch*AW +: AW] = dst;
        ch_length[ch*LW +: LW]   = len;
        ch_flags[ch*8 +: 8]      = flags;
        e.ch = 2'(ch); e.src = src; e.dst = dst; e.len = len; e.flags = flags; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic post(input logic [N-1:0] mask);
        ch_valid = mask;
        tick();
        ch_valid = '0;
    endtask

    // Engine model: wait for start, check descriptor, run WAIT, pulse done.
    task automatic service(input bit inject_err, input bit collide);
        exp_t e;
        logic [N-1:0] oh;
        int n = 0;
        while (eng_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout eng_start=%b required 1", eng_start);
            return;
        end
        e = exp_q.pop_front();
        oh = 4'(1) << e.ch;
        checks++;
        if (eng_channel_sel !== e.ch) begin
            errors++;
            $display("FAIL grant_sel got %0d required %0d", eng_channel_sel, e.ch);
        end
        checks++;
        if ({eng_src_addr, eng_dst_addr, eng_length, eng_flags} !== {e.src, e.dst, e.len, e.flags}) begin
            errors++;
            $display("FAIL desc_fields got %h/%h/%h/%h required %h/%h/%h/%h",
                     eng_src_addr, eng_dst_addr, eng_length, eng_flags, e.src, e.dst, e.len, e.flags);
        end
        tick();
        checks++;
        if (eng_start !== 1'b0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse start=%b busy=%b required 0/1", eng_start, sched_busy);
        end
        eng_error = inject_err;
        tick();
        eng_error = 1'b0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        exp_count++;
        if (collide) err_clear = oh;
        checks++;
        if (ch_done !== oh || ch_err !== (e.err ? oh : 4'b0) || xfer_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL completion done=%b err=%b cnt=%0d required %b/%b/%0d",
                     ch_done, ch_err, xfer_count, oh, (e.err ? oh : 4'b0), exp_count);
        end
        if (collide) begin
            tick();
            err_clear = '0;
            checks++;
            if ((err_status & oh) !== oh) begin
                errors++;
                $display("FAIL set_wins err_status=%b required bit %0d set", err_status, e.ch);
            end
        end
    endtask

    task automatic expect_reject();
        exp_t e;
        logic [N-1:0] oh;
        bit seen_start = 0;
        int n = 0;
        e = exp_q.pop_front();
        oh = 4'(1) << e.ch;
        while (ch_done === 4'b0 && n < 20) begin
            if (eng_start === 1'b1) seen_start = 1;
            tick();
            n++;
        end
        exp_count++;
        checks++;
        if (ch_done !== oh || ch_err !== oh || seen_start || xfer_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL reject done=%b err=%b start_seen=%0d cnt=%0d required %b/%b/0/%0d",
                     ch_done, ch_err, seen_start, xfer_count, oh, oh, exp_count);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ch_ready !== 4'hF || ch_done !== 4'h0 || ch_err !== 4'h0 || err_status !== 4'h0 ||
            eng_start !== 1'b0 || sched_busy !== 1'b0 || xfer_count !== 32'd0 ||
            eng_channel_sel !== 2'd0 || eng_src_addr !== '0 || eng_dst_addr !== '0 ||
            eng_length !== '0 || eng_flags !== '0) begin
            errors++;
            $display("FAIL reset_state ready=%h busy=%b start=%b cnt=%0d required F/0/0/0",
                     ch_ready, sched_busy, eng_start, xfer_count);
        end
    endtask

    task automatic test_single_read();
        load(1, 40'h00_1000_0000, 40'h0, 24'd64, 8'h01, 1'b0);
        post(4'b0010);
        checks++;
        if (ch_ready !== 4'b1101 || eng_start !== 1'b0) begin
            errors++;
            $display("FAIL accept_slot ready=%b start=%b required 1101/0", ch_ready, eng_start);
        end
        tick();
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL start_latency eng_start=%b required 1", eng_start);
        end
        service(1'b0, 1'b0);
        tick();
        checks++;
        if (ch_done !== 4'b0 || ch_ready !== 4'hF) begin
            errors++;
            $display("FAIL done_pulse done=%b ready=%h required 0/F", ch_done, ch_ready);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++)
            load(i, 40'(32'hA000_0000 + i * 32'h100), 40'(32'hB000_0000 + i), 24'(32 * (i + 1)), 8'(i), 1'b0);
        post(4'hF);
        service(1'b0, 1'b0);
        tick();
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back eng_start=%b required 1", eng_start);
        end
        service(1'b0, 1'b0);
        load(0, 40'h55_0000_0000, 40'h66, 24'd128, 8'h01, 1'b0);
        post(4'b0001);
        service(1'b0, 1'b0);
        load(2, 40'h77_0000_0000, 40'h88, 24'd16, 8'h00, 1'b0);
        post(4'b0100);
        service(1'b0, 1'b0);
        service(1'b0, 1'b0);
        service(1'b0, 1'b0);
    endtask

    task automatic test_illegal_length();
        load(3, 40'h1, 40'h2, 24'd0, 8'h00, 1'b1);
        post(4'b1000);
        expect_reject();
        load(2, 40'h3, 40'h4, 24'd24, 8'h01, 1'b1);
        post(4'b0100);
        expect_reject();
        tick();
        checks++;
        if (err_status !== 4'b1100) begin
            errors++;
            $display("FAIL err_status_set got %b required 1100", err_status);
        end
        err_clear = 4'b0100;
        tick();
        err_clear = 4'b0000;
        checks++;
        if (err_status !== 4'b1000) begin
            errors++;
            $display("FAIL err_clear got %b required 1000", err_status);
        end
    endtask

    task automatic test_engine_error();
        load(0, 40'h10, 40'h20, 24'd48, 8'h00, 1'b1);
        post(4'b0001);
        service(1'b1, 1'b0);
        tick();
        checks++;
        if (err_status !== 4'b1001) begin
            errors++;
            $display("FAIL eng_err_sticky got %b required 1001", err_status);
        end
        err_clear = 4'b0001;
        tick();
        err_clear = 4'b0000;
        checks++;
        if (err_status !== 4'b1000) begin
            errors++;
            $display("FAIL eng_err_clear got %b required 1000", err_status);
        end
        load(0, 40'h30, 40'h40, 24'd16, 8'h01, 1'b1);
        post(4'b0001);
        service(1'b1, 1'b1);
    endtask

    task automatic test_gating_busy();
        bit seen = 0;
        ch_enable = 4'b1101;
        load(1, 40'h111, 40'h222, 24'd32, 8'h01, 1'b0);
        post(4'b0010);
        for (int i = 0; i < 10; i++) begin
            if (eng_start === 1'b1) seen = 1;
            tick();
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++;
        if (seen || ch_ready[1] !== 1'b0 || sched_busy !== 1'b0 || ch_done !== 4'b0 ||
            xfer_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL gated start_seen=%0d ready=%b busy=%b done=%b cnt=%0d required 0/1101/0/0/%0d",
                     seen, ch_ready, sched_busy, ch_done, xfer_count, exp_count);
        end
        ch_enable = 4'hF;
        service(1'b0, 1'b0);
        seen = 0;
        eng_busy = 1'b1;
        load(2, 40'h333, 40'h444, 24'd16, 8'h00, 1'b0);
        post(4'b0100);
        for (int i = 0; i < 8; i++) begin
            if (eng_start === 1'b1) seen = 1;
            tick();
        end
        checks++;
        if (seen || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold start_seen=%0d busy=%b required 0/0", seen, sched_busy);
        end
        eng_busy = 1'b0;
        service(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        load(3, 40'h999, 40'haaa, 24'd64, 8'h01, 1'b0);
        post(4'b1000);
        while (eng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (sched_busy !== 1'b1 || xfer_count === 32'd0) begin
            errors++;
            $display("FAIL pre_reset busy=%b cnt=%0d required 1/nonzero", sched_busy, xfer_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 4'hF || sched_busy !== 1'b0 || eng_start !== 1'b0 || xfer_count !== 32'd0 ||
            err_status !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_wait ready=%h busy=%b start=%b cnt=%0d errst=%b required F/0/0/0/0",
                     ch_ready, sched_busy, eng_start, xfer_count, err_status);
        end
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_count = 0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        ch_valid = '0;
        ch_src_addr = '0;
        ch_dst_addr = '0;
        ch_length = '0;
        ch_flags = '0;
        ch_enable = 4'hF;
        err_clear = '0;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        eng_error = 1'b0;
        do_reset();
        test_reset();
        test_single_read();
        do_reset();
        test_round_robin();
        test_illegal_length();
        test_engine_error();
        test_gating_busy();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
